// File: rtl/route_pkg.sv
// Shared route-compute definitions for mesh NoC routers: route codes, order
// modes, skid-buffer states and the dimension-order route function.
package route_pkg;

  localparam int ROUTE_W = 3;
  localparam int COORD_W = 8;

  typedef logic [ROUTE_W-1:0] route_t;

  localparam route_t ROUTE_LOCAL = 3'd0;
  localparam route_t ROUTE_NORTH = 3'd1;
  localparam route_t ROUTE_EAST  = 3'd2;
  localparam route_t ROUTE_SOUTH = 3'd3;
  localparam route_t ROUTE_WEST  = 3'd4;

  localparam logic MODE_XY = 1'b0;
  localparam logic MODE_YX = 1'b1;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  // Coordinates are zero-extended into coord_t by the caller, so one function
  // serves any mesh size up to 2**COORD_W per dimension.
  function automatic route_t route_compute(input coord_t router_addr,
                                           input coord_t dest_addr,
                                           input logic   mode);
    route_t x_route;
    route_t y_route;
    x_route = (dest_addr.x > router_addr.x) ? ROUTE_EAST  :
              (dest_addr.x < router_addr.x) ? ROUTE_WEST  : ROUTE_LOCAL;
    y_route = (dest_addr.y > router_addr.y) ? ROUTE_NORTH :
              (dest_addr.y < router_addr.y) ? ROUTE_SOUTH : ROUTE_LOCAL;
    if (mode == MODE_YX) begin
      return (y_route != ROUTE_LOCAL) ? y_route : x_route;
    end
    return (x_route != ROUTE_LOCAL) ? x_route : y_route;
  endfunction

endpackage

// File: rtl/xy_route_stage_skid_buffer_2.sv
// Two-entry valid/ready register slice: main drives the outputs, skid catches
// the flit accepted while the downstream stalls. in_ready is a pure state decode.
module skid_buffer_2
  import route_pkg::*;
#(
  parameter int DATA_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  skid_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;

  assign in_ready  = (state_q != SKID_FULL);
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;

  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && out_ready) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = SKID_FULL;
        end else if (out_ready) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // NOTE: the data registers are reset too, because out_header must read zero
  // after reset; <= keeps every flop updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/xy_route_stage.sv
// Dimension-order route-compute stage: prepends a route code to each header
// flit, drops flits with out-of-range destinations and counts them.
module xy_route_stage
  import route_pkg::*;
#(
  parameter int X_BITS   = 2,
  parameter int Y_BITS   = 2,
  parameter int MESH_X   = 4,
  parameter int MESH_Y   = 4,
  parameter int HEADER_W = 16,
  parameter int PORT_W   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [X_BITS+Y_BITS-1:0]   router_address,
  input  logic                       yx_mode,
  input  logic [HEADER_W-1:0]        in_header,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PORT_W+HEADER_W-1:0] out_header,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       dest_error,
  output logic [7:0]                 drop_count
);

  logic [X_BITS-1:0]          dest_x, rtr_x;
  logic [Y_BITS-1:0]          dest_y, rtr_y;
  logic                       x_oob, y_oob, dest_bad;
  logic                       accept, push, drop;
  coord_t                     rtr_c, dest_c;
  route_t                     route;
  logic [PORT_W+HEADER_W-1:0] tagged_header;

  logic       dest_error_q, dest_error_d;
  logic [7:0] drop_count_q, drop_count_d;

  assign dest_x = in_header[X_BITS+Y_BITS-1:Y_BITS];
  assign dest_y = in_header[Y_BITS-1:0];
  assign rtr_x  = router_address[X_BITS+Y_BITS-1:Y_BITS];
  assign rtr_y  = router_address[Y_BITS-1:0];

  // A full power-of-two dimension cannot hold an out-of-range coordinate.
  if (MESH_X < (1 << X_BITS)) begin : g_x_check
    assign x_oob = (dest_x >= X_BITS'(MESH_X));
  end else begin : g_x_full
    assign x_oob = 1'b0;
  end

  if (MESH_Y < (1 << Y_BITS)) begin : g_y_check
    assign y_oob = (dest_y >= Y_BITS'(MESH_Y));
  end else begin : g_y_full
    assign y_oob = 1'b0;
  end

  assign dest_bad = x_oob || y_oob;
  assign accept   = in_valid && in_ready;
  assign push     = accept && !dest_bad;
  assign drop     = accept && dest_bad;

  assign rtr_c  = '{x: COORD_W'(rtr_x),  y: COORD_W'(rtr_y)};
  assign dest_c = '{x: COORD_W'(dest_x), y: COORD_W'(dest_y)};
  assign route  = route_compute(rtr_c, dest_c, yx_mode);

  assign tagged_header = {PORT_W'(route), in_header};

  skid_buffer_2 #(
    .DATA_W(PORT_W + HEADER_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  (tagged_header),
    .in_valid (push),
    .in_ready (in_ready),
    .out_data (out_header),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always_comb begin
    dest_error_d = dest_error_q | drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dest_error_q <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      dest_error_q <= dest_error_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign dest_error = dest_error_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_xy_route_stage.sv
// Scoreboard bench for xy_route_stage: a default 4x4 instance for routing and
// flow control, and a 3-column instance for out-of-range drops.
module tb_xy_route_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  router_address;
  logic        yx_mode;
  logic [15:0] in_header;
  logic        in_valid, in_valid_b;
  logic        in_ready, in_ready_b;
  logic [18:0] out_header, out_header_b;
  logic        out_valid, out_valid_b;
  logic        out_ready;
  logic        dest_error, dest_error_b;
  logic [7:0]  drop_count, drop_count_b;

  int checks   = 0;
  int failures = 0;
  logic [18:0] sb[$];

  always #5 clk = ~clk;

  xy_route_stage dut (
    .clk(clk), .reset(reset), .router_address(router_address), .yx_mode(yx_mode),
    .in_header(in_header), .in_valid(in_valid), .in_ready(in_ready),
    .out_header(out_header), .out_valid(out_valid), .out_ready(out_ready),
    .dest_error(dest_error), .drop_count(drop_count)
  );

  xy_route_stage #(.MESH_X(3)) dut_b (
    .clk(clk), .reset(reset), .router_address(router_address), .yx_mode(yx_mode),
    .in_header(in_header), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_header(out_header_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .dest_error(dest_error_b), .drop_count(drop_count_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference router: destination vs. router coordinate, one dimension at a time.
  function automatic logic [2:0] exp_route(input logic [3:0] rtr, input logic [3:0] dst,
                                           input logic yx);
    int rx = int'(rtr[3:2]);
    int ry = int'(rtr[1:0]);
    int dx = int'(dst[3:2]);
    int dy = int'(dst[1:0]);
    logic [2:0] by_x, by_y;
    if (dx > rx)      by_x = 3'd2;
    else if (dx < rx) by_x = 3'd4;
    else              by_x = 3'd0;
    if (dy > ry)      by_y = 3'd1;
    else if (dy < ry) by_y = 3'd3;
    else              by_y = 3'd0;
    if (yx) return (by_y != 3'd0) ? by_y : by_x;
    return (by_x != 3'd0) ? by_x : by_y;
  endfunction

  // Monitor on the falling edge: values seen here are what the next rising edge uses.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          check("sb_out_header", 32'(out_header), 32'(sb.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({exp_route(router_address, in_header[3:0], yx_mode), in_header});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk_hdr(input logic [1:0] x, input logic [1:0] y);
    logic [11:0] upper = 12'($urandom);
    return {upper, x, y};
  endfunction

  // Hold one flit on the chosen instance until accepted; returns just after the accepting edge.
  task automatic send(input logic [15:0] hdr, input bit to_b);
    int  n    = 0;
    bit  done = 1'b0;
    in_header = hdr;
    if (to_b) in_valid_b = 1'b1;
    else      in_valid   = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      done = to_b ? in_ready_b : in_ready;
      tick();
      n++;
    end
    in_valid   = 1'b0;
    in_valid_b = 1'b0;
    if (!done) check("send_timeout", 32'(n), 32'd0);
  endtask

  logic [15:0] hdrs[4];
  logic [15:0] h;
  int          idx;
  bit          acc;

  initial begin
    reset          = 1'b1;
    router_address = {2'd2, 2'd1};
    yx_mode        = 1'b0;
    in_header      = '0;
    in_valid       = 1'b0;
    in_valid_b     = 1'b0;
    out_ready      = 1'b1;
    tick();
    tick();
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_dest_error", 32'(dest_error), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_out_header", 32'(out_header), 32'd0);
    reset = 1'b0;
    tick();

    // XY order: EAST, NORTH, LOCAL, each visible right after its accepting edge.
    h = mk_hdr(2'd3, 2'd0); send(h, 1'b0);
    check("xy_east_valid", 32'(out_valid), 32'd1);
    check("xy_east_hdr",   32'(out_header), 32'({3'd2, h}));
    h = mk_hdr(2'd2, 2'd3); send(h, 1'b0);
    check("xy_north_valid", 32'(out_valid), 32'd1);
    check("xy_north_hdr",   32'(out_header), 32'({3'd1, h}));
    h = mk_hdr(2'd2, 2'd1); send(h, 1'b0);
    check("xy_local_valid", 32'(out_valid), 32'd1);
    check("xy_local_hdr",   32'(out_header), 32'({3'd0, h}));

    // YX order.
    yx_mode = 1'b1;
    h = mk_hdr(2'd0, 2'd3); send(h, 1'b0);
    check("yx_north_hdr", 32'(out_header), 32'({3'd1, h}));
    h = mk_hdr(2'd0, 2'd1); send(h, 1'b0);
    check("yx_west_hdr", 32'(out_header), 32'({3'd4, h}));
    yx_mode = 1'b0;
    h = mk_hdr(2'd0, 2'd3); send(h, 1'b0);
    check("xy_after_switch_hdr", 32'(out_header), 32'({3'd4, h}));
    tick();

    // Backpressure: four flits offered against a stalled output.
    for (int i = 0; i < 4; i++) hdrs[i] = mk_hdr(2'(i), 2'(3 - i));
    out_ready = 1'b0;
    idx       = 0;
    in_header = hdrs[0];
    in_valid  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        idx++;
        in_header = hdrs[idx];
        if (idx == 2) check("bp_in_ready_full", 32'(in_ready), 32'd0);
      end
    end
    check("bp_captured", 32'(idx), 32'd2);
    check("bp_held_hdr", 32'(out_header[15:0]), 32'(hdrs[0]));
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_stream_valid", 32'(out_valid), 32'd1);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx == 4) in_valid = 1'b0;
        else          in_header = hdrs[idx];
      end
    end
    check("bp_all_sent", 32'(idx), 32'd4);
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset with two flits buffered: they must never emerge.
    out_ready = 1'b0;
    send(mk_hdr(2'd1, 2'd0), 1'b0);
    send(mk_hdr(2'd3, 2'd2), 1'b0);
    check("mid_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    check("mid_rst_out_valid",  32'(out_valid),  32'd0);
    check("mid_rst_in_ready",   32'(in_ready),   32'd1);
    check("mid_rst_out_header", 32'(out_header), 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("mid_post_valid", 32'(out_valid), 32'd0);

    // Out-of-range destinations on the 3-column instance.
    send(mk_hdr(2'd3, 2'd0), 1'b1);
    check("oob_no_out",     32'(out_valid_b),    32'd0);
    check("oob_dest_error", 32'(dest_error_b),   32'd1);
    check("oob_drop_one",   32'(drop_count_b),   32'd1);
    h = mk_hdr(2'd1, 2'd1); send(h, 1'b1);
    check("oob_next_valid", 32'(out_valid_b),  32'd1);
    check("oob_next_hdr",   32'(out_header_b), 32'({3'd4, h}));
    in_valid_b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_header = mk_hdr(2'd3, 2'(i));
      tick();
      if (i == 253) check("oob_drop_254", 32'(drop_count_b), 32'd255);
    end
    in_valid_b = 1'b0;
    check("oob_sat",         32'(drop_count_b), 32'd255);
    check("oob_error_stuck", 32'(dest_error_b), 32'd1);
    check("oob_drained",     32'(out_valid_b),  32'd0);
    check("main_no_error",   32'(dest_error),   32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
